tmr_err_collector: RTL and testbench

//   Downstream consumer of the tmrx_error_sink outputs (err_o of top and submodules).

---
 rtl/tmr_err_collector.sv | 185 ++++++++++++++++++
 tb/tb_tmr_err_collector.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tmr_err_collector.sv
// tmr_err_collector
// Collects N_SRC voter-mismatch flags from the TMR error sinks. Keeps a sticky
// bit, a saturating rise counter and an overflow flag per source, and drives an
// aggregate error and a maskable interrupt. Entries are cleared by a
// valid/ready request, followed by a holdoff window in which no new clear is
// accepted. A source that is erroring in the clear cycle keeps its sticky bit
// and restarts its counter at 1.
module tmr_err_collector #(
   parameter  int N_SRC       = 4,
   parameter  int CNT_W       = 8,
   parameter  int HOLDOFF_CYC = 2,
   localparam int SEL_W       = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [N_SRC-1:0]   err_i,
   input  logic [N_SRC-1:0]   irq_en_i,
   input  logic               clr_valid_i,
   input  logic [N_SRC-1:0]   clr_mask_i,
   output logic               clr_ready_o,
   input  logic [SEL_W-1:0]   cnt_sel_i,
   output logic [CNT_W-1:0]   cnt_o,
   output logic [N_SRC-1:0]   sticky_o,
   output logic [N_SRC-1:0]   overflow_o,
   output logic               err_o,
   output logic               irq_o
);

   // Last holdoff count value; the counter runs 0..HO_LAST inside HOLDOFF.
   localparam int HO_LAST = (HOLDOFF_CYC > 0) ? HOLDOFF_CYC - 1 : 0;
   localparam int HO_W    = (HO_LAST > 0) ? $clog2(HO_LAST + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CLEAR   = 2'd1,
      ST_HOLDOFF = 2'd2
   } state_e;

   state_e              state_reg, state_next;
   logic                ready_reg;
   logic [N_SRC-1:0]    mask_reg, mask_next;
   logic [HO_W-1:0]     hold_reg, hold_next;
   logic                clr_active;

   logic [N_SRC-1:0]    err_q_reg;
   logic [N_SRC-1:0]    rise;
   logic [N_SRC-1:0]    clr_now;
   logic [N_SRC-1:0]    sticky_vec;
   logic [N_SRC-1:0]    sticky_next_vec;
   logic [N_SRC-1:0]    ovf_vec;
   logic [N_SRC*CNT_W-1:0] cnt_flat;

   logic                err_reg;
   logic                irq_reg;

   assign rise    = err_i & ~err_q_reg;
   assign clr_now = {N_SRC{clr_active}} & mask_reg;

   // Clear-request FSM: next state, mask capture and holdoff counting.
   always_comb begin
      state_next = state_reg;
      mask_next  = mask_reg;
      hold_next  = hold_reg;
      clr_active = 1'b0;
      unique case (state_reg)
         ST_IDLE: begin
            if (clr_valid_i && ready_reg) begin
               mask_next  = clr_mask_i;
               state_next = ST_CLEAR;
            end
         end
         ST_CLEAR: begin
            clr_active = 1'b1;
            hold_next  = '0;
            state_next = (HOLDOFF_CYC > 0) ? ST_HOLDOFF : ST_IDLE;
         end
         ST_HOLDOFF: begin
            if (hold_reg == HO_W'(HO_LAST)) begin
               state_next = ST_IDLE;
            end else begin
               hold_next = hold_reg + 1'b1;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // FSM registers; ready is a registered decode of the upcoming state.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_reg <= ST_IDLE;
         ready_reg <= 1'b1;
         mask_reg  <= '0;
         hold_reg  <= '0;
      end else begin
         state_reg <= state_next;
         ready_reg <= (state_next == ST_IDLE);
         mask_reg  <= mask_next;
         hold_reg  <= hold_next;
      end
   end

   // Previous-cycle copy of the raw flags for rise detection.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_q_reg <= '0;
      end else begin
         err_q_reg <= err_i;
      end
   end

   generate
      for (genvar gi = 0; gi < N_SRC; gi++) begin : g_src
         logic             sticky_reg;
         logic             ovf_reg, ovf_next;
         logic [CNT_W-1:0] cnt_reg, cnt_next;

         // A live error wins over a clear landing in the same cycle.
         assign sticky_next_vec[gi] = (sticky_reg & ~clr_now[gi]) | err_i[gi];

         // Saturating rise counter; a rise during the clear restarts it at 1.
         always_comb begin
            cnt_next = cnt_reg;
            ovf_next = ovf_reg;
            if (clr_now[gi]) begin
               cnt_next = rise[gi] ? CNT_W'(1) : '0;
               ovf_next = 1'b0;
            end else if (rise[gi]) begin
               if (cnt_reg == {CNT_W{1'b1}}) begin
                  ovf_next = 1'b1;
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
         end

         // Per-source sticky, counter and overflow state.
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               sticky_reg <= 1'b0;
               cnt_reg    <= '0;
               ovf_reg    <= 1'b0;
            end else begin
               sticky_reg <= sticky_next_vec[gi];
               cnt_reg    <= cnt_next;
               ovf_reg    <= ovf_next;
            end
         end

         assign sticky_vec[gi]                  = sticky_reg;
         assign ovf_vec[gi]                     = ovf_reg;
         assign cnt_flat[gi*CNT_W +: CNT_W]     = cnt_reg;
      end
   endgenerate

   // Aggregates follow the sticky bits in the same edge they are set.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         err_reg <= 1'b0;
         irq_reg <= 1'b0;
      end else begin
         err_reg <= |sticky_next_vec;
         irq_reg <= |(sticky_next_vec & irq_en_i);
      end
   end

   // Counter readout; out-of-range selects read as zero.
   always_comb begin
      cnt_o = '0;
      for (int i = 0; i < N_SRC; i++) begin
         if (int'(cnt_sel_i) == i) begin
            cnt_o = cnt_flat[i*CNT_W +: CNT_W];
         end
      end
   end

   assign clr_ready_o = ready_reg;
   assign sticky_o    = sticky_vec;
   assign overflow_o  = ovf_vec;
   assign err_o       = err_reg;
   assign irq_o       = irq_reg;

endmodule

// File: tb/tb_tmr_err_collector.sv
// Directed bench for tmr_err_collector. Two instances share all inputs: one
// with default parameters and one with a 2-bit counter for saturation checks.
// Expected values are queued when stimulus is driven and popped at checks.
module tb_tmr_err_collector;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [3:0] err_i;
   logic [3:0] irq_en_i;
   logic       clr_valid_i;
   logic [3:0] clr_mask_i;
   logic [1:0] cnt_sel_i;

   logic       ready_a, ready_b;
   logic [7:0] cnt_a;
   logic [1:0] cnt_b;
   logic [3:0] sticky_a, sticky_b;
   logic [3:0] ovf_a, ovf_b;
   logic       err_a, err_b;
   logic       irq_a, irq_b;

   int n_tests = 0;
   int n_fail  = 0;

   string       sb_tag[$];
   logic [31:0] sb_val[$];

   tmr_err_collector #(.N_SRC(4), .CNT_W(8), .HOLDOFF_CYC(2)) u_dut (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .err_i       (err_i),
      .irq_en_i    (irq_en_i),
      .clr_valid_i (clr_valid_i),
      .clr_mask_i  (clr_mask_i),
      .clr_ready_o (ready_a),
      .cnt_sel_i   (cnt_sel_i),
      .cnt_o       (cnt_a),
      .sticky_o    (sticky_a),
      .overflow_o  (ovf_a),
      .err_o       (err_a),
      .irq_o       (irq_a)
   );

   tmr_err_collector #(.N_SRC(4), .CNT_W(2), .HOLDOFF_CYC(2)) u_dut2 (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .err_i       (err_i),
      .irq_en_i    (irq_en_i),
      .clr_valid_i (clr_valid_i),
      .clr_mask_i  (clr_mask_i),
      .clr_ready_o (ready_b),
      .cnt_sel_i   (cnt_sel_i),
      .cnt_o       (cnt_b),
      .sticky_o    (sticky_b),
      .overflow_o  (ovf_b),
      .err_o       (err_b),
      .irq_o       (irq_b)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: observed timeout expected $finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic sb_push(input string tag, input logic [31:0] val);
      sb_tag.push_back(tag);
      sb_val.push_back(val);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs);
      string       etag;
      logic [31:0] eval;
      n_tests++;
      if (sb_val.size() == 0) begin
         n_fail++;
         $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, obs);
      end else begin
         etag = sb_tag.pop_front();
         eval = sb_val.pop_front();
         $display("[TB] check %-14s obs=%0h exp=%0h", tag, obs, eval);
         assert (obs === eval && etag == tag) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h (queued tag %s)", tag, obs, eval, etag);
         end
      end
   endtask

   initial begin
      int acc_n;
      int acc_c[$];

      rst_ni      = 1'b0;
      err_i       = '0;
      irq_en_i    = '0;
      clr_valid_i = 1'b0;
      clr_mask_i  = '0;
      cnt_sel_i   = 2'd0;

      // Reset state
      tick(); tick();
      sb_push("rst_ready", 1);   chk("rst_ready", ready_a);
      sb_push("rst_sticky", 0);  chk("rst_sticky", sticky_a);
      sb_push("rst_err", 0);     chk("rst_err", err_a);
      sb_push("rst_irq", 0);     chk("rst_irq", irq_a);
      sb_push("rst_cnt", 0);     chk("rst_cnt", cnt_a);
      sb_push("rst_ovf", 0);     chk("rst_ovf", ovf_a);
      rst_ni = 1'b1;
      tick(); tick();
      sb_push("idle_err", 0);    chk("idle_err", err_a);
      sb_push("idle_ready", 1);  chk("idle_ready", ready_a);

      // Three single-cycle pulses on source 2
      err_i = 4'b0100;
      sb_push("p2_sticky1", 4'b0100);
      sb_push("p2_err1", 1);
      tick();
      chk("p2_sticky1", sticky_a);
      chk("p2_err1", err_a);
      err_i = 4'b0000; tick();
      err_i = 4'b0100; tick();
      err_i = 4'b0000; tick();
      err_i = 4'b0100; tick();
      err_i = 4'b0000; tick();
      cnt_sel_i = 2'd2;
      sb_push("p2_cnt", 3);      sb_push("p2_cnt_b", 3);
      sb_push("p2_sticky", 4'b0100);
      sb_push("p2_irq", 0);
      #1;
      chk("p2_cnt", cnt_a);
      chk("p2_cnt_b", cnt_b);
      chk("p2_sticky", sticky_a);
      chk("p2_irq", irq_a);

      // Source 0 held high for ten cycles counts one rise
      err_i = 4'b0001;
      sb_push("h0_sticky", 4'b0101);
      tick();
      chk("h0_sticky", sticky_a);
      repeat (9) tick();
      err_i = 4'b0000;
      tick();
      cnt_sel_i = 2'd0;
      sb_push("h0_cnt", 1);
      sb_push("h0_irq_off", 0);
      #1;
      chk("h0_cnt", cnt_a);
      chk("h0_irq_off", irq_a);
      irq_en_i = 4'b0001;
      sb_push("h0_irq_on", 1);
      tick();
      chk("h0_irq_on", irq_a);

      // Full clear, then holdoff timing
      clr_valid_i = 1'b1;
      clr_mask_i  = 4'b1111;
      sb_push("c_ready_clr", 0);
      tick();
      clr_valid_i = 1'b0;
      chk("c_ready_clr", ready_a);
      sb_push("c_sticky", 0);
      sb_push("c_err", 0);
      sb_push("c_irq", 0);
      sb_push("c_cnt0", 0);
      sb_push("c_ready_h1", 0);
      tick();
      chk("c_sticky", sticky_a);
      chk("c_err", err_a);
      chk("c_irq", irq_a);
      chk("c_cnt0", cnt_a);
      chk("c_ready_h1", ready_a);
      sb_push("c_ready_h2", 0);
      tick();
      chk("c_ready_h2", ready_a);
      sb_push("c_ready_back", 1);
      tick();
      chk("c_ready_back", ready_a);

      // Five rises on source 1: the 2-bit counter saturates
      for (int k = 0; k < 5; k++) begin
         err_i = 4'b0010; tick();
         err_i = 4'b0000; tick();
      end
      cnt_sel_i = 2'd1;
      sb_push("ov_cnt_b", 3);
      sb_push("ov_ovf_b", 4'b0010);
      sb_push("ov_cnt_a", 5);
      sb_push("ov_ovf_a", 0);
      #1;
      chk("ov_cnt_b", cnt_b);
      chk("ov_ovf_b", ovf_b);
      chk("ov_cnt_a", cnt_a);
      chk("ov_ovf_a", ovf_a);
      clr_valid_i = 1'b1;
      clr_mask_i  = 4'b0010;
      tick();
      clr_valid_i = 1'b0;
      sb_push("ov_clr_cnt", 0);
      sb_push("ov_clr_ovf", 0);
      sb_push("ov_clr_sticky", 0);
      tick();
      chk("ov_clr_cnt", cnt_b);
      chk("ov_clr_ovf", ovf_b);
      chk("ov_clr_sticky", sticky_b);
      tick(); tick();

      // Clear-all while source 3 rises in the clear cycle; mask changes late
      err_i = 4'b0101; tick();
      err_i = 4'b0000; tick();
      clr_valid_i = 1'b1;
      clr_mask_i  = 4'b1111;
      tick();
      clr_valid_i = 1'b0;
      clr_mask_i  = 4'b0000;
      err_i       = 4'b1000;
      sb_push("sb_sticky", 4'b1000);
      sb_push("sb_err", 1);
      sb_push("sb_irq", 0);
      tick();
      err_i = 4'b0000;
      chk("sb_sticky", sticky_a);
      chk("sb_err", err_a);
      chk("sb_irq", irq_a);
      cnt_sel_i = 2'd3;
      sb_push("sb_cnt3", 1);   sb_push("sb_cnt3_b", 1);
      #1;
      chk("sb_cnt3", cnt_a);
      chk("sb_cnt3_b", cnt_b);
      cnt_sel_i = 2'd0;
      sb_push("sb_cnt0", 0);
      #1;
      chk("sb_cnt0", cnt_a);
      cnt_sel_i = 2'd2;
      sb_push("sb_cnt2", 0);
      #1;
      chk("sb_cnt2", cnt_a);
      tick(); tick();

      // Valid held high: accepts every four cycles
      clr_valid_i = 1'b1;
      clr_mask_i  = 4'b0000;
      acc_n = 0;
      for (int c = 0; c < 8; c++) begin
         if (ready_a === 1'b1) begin
            acc_n++;
            acc_c.push_back(c);
         end
         tick();
      end
      clr_valid_i = 1'b0;
      sb_push("hv_accepts", 2);
      chk("hv_accepts", acc_n);
      sb_push("hv_spacing", 4);
      chk("hv_spacing", (acc_c.size() == 2) ? (acc_c[1] - acc_c[0]) : -1);
      sb_push("hv_ready_end", 1);
      chk("hv_ready_end", ready_a);

      // Reset asserted in the middle of holdoff
      clr_valid_i = 1'b1;
      tick();
      clr_valid_i = 1'b0;
      tick(); tick();
      sb_push("mh_ready_h", 0);
      chk("mh_ready_h", ready_a);
      rst_ni = 1'b0;
      #2;
      sb_push("mh_ready_rst", 1);
      sb_push("mh_sticky_rst", 0);
      sb_push("mh_err_rst", 0);
      chk("mh_ready_rst", ready_a);
      chk("mh_sticky_rst", sticky_a);
      chk("mh_err_rst", err_a);
      tick();
      rst_ni = 1'b1;
      tick();
      sb_push("mh_ready_rel", 1);
      chk("mh_ready_rel", ready_a);
      clr_valid_i = 1'b1;
      sb_push("mh_accept", 0);
      tick();
      clr_valid_i = 1'b0;
      chk("mh_accept", ready_a);
      repeat (4) tick();

      sb_push("sb_drained", 0);
      chk("sb_drained", sb_val.size() - 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
